debounce_bank: RTL and testbench

//  Parametrised multi-channel debouncer for push-buttons and slide switches on the board.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 101 ++++++++++
 rtl/debounce_bank.sv | 58 +++++
 tb/tb_debounce_bank.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce bank.
//   cnt_t       : stability counter / threshold type at the default width
//   level_e     : debounced level, ST_IDLE = released, ST_ACTIVE = pressed
//   DEFAULT_*   : default parameter values used by debounce_bank/debounce_channel
package debounce_pkg;

  localparam int DEFAULT_CNT_W       = 16;
  localparam int DEFAULT_LONG_CYCLES = 50_000_000;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } level_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability filter and, when
// DEBOUNCE_BANK_LONG_PRESS_EN is defined, a saturating long-press hold counter.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_pb             raw asynchronous input
//   i_thresh         stability threshold in cycles
//   o_pb_state       debounced level
//   o_press          1-cycle pulse on IDLE_LEVEL -> ~IDLE_LEVEL
//   o_release        1-cycle pulse on ~IDLE_LEVEL -> IDLE_LEVEL
//   o_long_press     1-cycle pulse once per press after LONG_CYCLES held (0 without macro)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   CNT_W       = DEFAULT_CNT_W,
  parameter logic IDLE_LEVEL  = 1'b1
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  ,
  parameter int   HOLD_W      = 26,
  parameter int   LONG_CYCLES = DEFAULT_LONG_CYCLES
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pb,
  input  logic [CNT_W-1:0] i_thresh,
  output logic             o_pb_state,
  output logic             o_press,
  output logic             o_release,
  output logic             o_long_press
);

  logic             r_sync0;
  logic             r_sync1;
  level_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;
  logic             w_sync_active;

  assign w_sync_active = (r_sync1 != IDLE_LEVEL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync0   <= IDLE_LEVEL;
      r_sync1   <= IDLE_LEVEL;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync0   <= i_pb;
      r_sync1   <= r_sync0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_sync_active == (r_state == ST_ACTIVE)) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_thresh) begin
        // >= rather than == so a threshold lowered below the running count
        // still commits; it also stops cnt before it could ever wrap.
        r_state   <= w_sync_active ? ST_ACTIVE : ST_IDLE;
        r_cnt     <= '0;
        r_press   <= w_sync_active;
        r_release <= ~w_sync_active;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pb_state = (r_state == ST_ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
  assign o_press    = r_press;
  assign o_release  = r_release;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  logic [HOLD_W-1:0] r_hold;
  logic              r_long_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold       <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if (r_state == ST_ACTIVE) begin
        // Saturate at LONG_CYCLES so the pulse fires only once per press.
        if (r_hold != HOLD_W'(LONG_CYCLES)) begin
          r_hold       <= r_hold + HOLD_W'(1);
          r_long_press <= (r_hold == HOLD_W'(LONG_CYCLES - 1));
        end
      end else begin
        r_hold <= '0;
      end
    end
  end

  assign o_long_press = r_long_press;
`else
  assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button / switch debouncer. N_CH independent channels share
// clock, reset and a runtime stability threshold.
// Optional long-press detection is enabled by defining DEBOUNCE_BANK_LONG_PRESS_EN.
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_pb_in        raw asynchronous inputs [N_CH]
//   i_thresh       stability threshold in cycles [CNT_W]
//   o_pb_state     debounced levels [N_CH]
//   o_press        press event pulses [N_CH]
//   o_release      release event pulses [N_CH]
//   o_long_press   long-press pulses [N_CH], all 0 without the macro
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N_CH        = 4,
  parameter int   CNT_W       = DEFAULT_CNT_W,
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   HOLD_W      = 26,
  parameter int   LONG_CYCLES = DEFAULT_LONG_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_CH-1:0]  i_pb_in,
  input  logic [CNT_W-1:0] i_thresh,
  output logic [N_CH-1:0]  o_pb_state,
  output logic [N_CH-1:0]  o_press,
  output logic [N_CH-1:0]  o_release,
  output logic [N_CH-1:0]  o_long_press
);

  // The hold counter must be able to reach LONG_CYCLES.
  if (LONG_CYCLES < 1 || $clog2(LONG_CYCLES + 1) > HOLD_W) begin : g_bad_hold_cfg
    $error("debounce_bank: HOLD_W too narrow for LONG_CYCLES");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .CNT_W       (CNT_W),
      .IDLE_LEVEL  (IDLE_LEVEL)
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
      ,
      .HOLD_W      (HOLD_W),
      .LONG_CYCLES (LONG_CYCLES)
`endif
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pb         (i_pb_in[g]),
      .i_thresh     (i_thresh),
      .o_pb_state   (o_pb_state[g]),
      .o_press      (o_press[g]),
      .o_release    (o_release[g]),
      .o_long_press (o_long_press[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pb_in;
  logic [15:0] thresh;
  logic [3:0]  pb_state;
  logic [3:0]  press;
  logic [3:0]  rel;
  logic [3:0]  long_press;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int press_cnt[4];
  int press_cyc[4];
  int rel_cnt[4];
  int rel_cyc[4];
  int long_cnt[4];
  int long_cyc[4];
  int both_cnt   = 0;
  int long_total = 0;

  debounce_bank #(
    .N_CH        (4),
    .CNT_W       (16),
    .IDLE_LEVEL  (1'b1),
    .HOLD_W      (26),
    .LONG_CYCLES (20)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pb_in      (pb_in),
    .i_thresh     (thresh),
    .o_pb_state   (pb_state),
    .o_press      (press),
    .o_release    (rel),
    .o_long_press (long_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: after rising edge k, cyc == k at the following falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (press[c] === 1'b1) begin press_cnt[c]++; press_cyc[c] = cyc; end
      if (rel[c] === 1'b1)   begin rel_cnt[c]++;   rel_cyc[c]   = cyc; end
      if (long_press[c] === 1'b1) begin long_cnt[c]++; long_cyc[c] = cyc; long_total++; end
      if (press[c] === 1'b1 && rel[c] === 1'b1) both_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_events();
    for (int c = 0; c < 4; c++) begin
      press_cnt[c] = 0; press_cyc[c] = -1;
      rel_cnt[c]   = 0; rel_cyc[c]   = -1;
      long_cnt[c]  = 0; long_cyc[c]  = -1;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pb_in  = 4'b0000;
    thresh = 16'd10;
    tick(1);
    clear_events();
    tick(3);
    checks++;
    if (pb_state !== 4'b1111) begin
      errors++; $display("FAIL reset_state: got %b want 1111", pb_state);
    end
    checks++;
    if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] != 0) begin
      errors++; $display("FAIL reset_no_pulses: events seen during reset");
    end
    rst = 1'b0;
    tick(12);
    checks++;
    if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] != 0 || pb_state !== 4'b1111) begin
      errors++; $display("FAIL reset_filter_hold: pb_state %b, presses seen before edge 13", pb_state);
    end
    tick(1);
    checks++;
    if (press !== 4'b1111 || pb_state !== 4'b0000) begin
      errors++; $display("FAIL reset_first_press: press %b state %b want 1111/0000", press, pb_state);
    end
    pb_in = 4'b1111;
    tick(13);
    checks++;
    if (rel !== 4'b1111 || pb_state !== 4'b1111) begin
      errors++; $display("FAIL reset_release_all: release %b state %b want 1111/1111", rel, pb_state);
    end
    tick(1);
    checks++;
    if (rel !== 4'b0000 || press !== 4'b0000) begin
      errors++; $display("FAIL pulse_width: release %b press %b want 0000", rel, press);
    end
  endtask

  task automatic test_clean_press();
    int s;
    thresh = 16'd10;
    clear_events();
    pb_in[0] = 1'b0;
    s = cyc;
    tick(20);
    checks++;
    if (press_cnt[0] != 1 || press_cyc[0] != s + 13) begin
      errors++; $display("FAIL clean_press: count %0d at edge %0d want 1 at %0d", press_cnt[0], press_cyc[0] - s, 13);
    end
    checks++;
    if (rel_cnt[0] != 0 || pb_state !== 4'b1110) begin
      errors++; $display("FAIL clean_press_state: releases %0d state %b want 0 / 1110", rel_cnt[0], pb_state);
    end
    pb_in[0] = 1'b1;
    s = cyc;
    tick(20);
    checks++;
    if (rel_cnt[0] != 1 || rel_cyc[0] != s + 13) begin
      errors++; $display("FAIL clean_release: count %0d at edge %0d want 1 at 13", rel_cnt[0], rel_cyc[0] - s);
    end
  endtask

  task automatic test_bounce();
    int s;
    thresh = 16'd10;
    clear_events();
    for (int i = 0; i < 10; i++) begin
      pb_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(4);
    end
    checks++;
    if (press_cnt[1] != 0 || rel_cnt[1] != 0) begin
      errors++; $display("FAIL bounce_quiet: presses %0d releases %0d want 0/0", press_cnt[1], rel_cnt[1]);
    end
    pb_in[1] = 1'b0;
    s = cyc;
    tick(25);
    checks++;
    if (press_cnt[1] != 1 || press_cyc[1] != s + 13 || rel_cnt[1] != 0) begin
      errors++; $display("FAIL bounce_settle: presses %0d at edge %0d releases %0d want 1 at 13, 0", press_cnt[1], press_cyc[1] - s, rel_cnt[1]);
    end
    pb_in[1] = 1'b1;
    tick(15);
  endtask

  task automatic test_threshold_edge();
    int s;
    thresh = 16'd0;
    clear_events();
    pb_in[2] = 1'b0;
    s = cyc;
    tick(1);
    pb_in[2] = 1'b1;
    tick(8);
    checks++;
    if (press_cnt[2] != 1 || press_cyc[2] != s + 3) begin
      errors++; $display("FAIL thresh0_press: count %0d at edge %0d want 1 at 3", press_cnt[2], press_cyc[2] - s);
    end
    checks++;
    if (rel_cnt[2] != 1 || rel_cyc[2] != s + 4) begin
      errors++; $display("FAIL thresh0_release: count %0d at edge %0d want 1 at 4", rel_cnt[2], rel_cyc[2] - s);
    end
    thresh = 16'd1;
    clear_events();
    pb_in[2] = 1'b0;
    tick(1);
    pb_in[2] = 1'b1;
    tick(8);
    checks++;
    if (press_cnt[2] != 0 || rel_cnt[2] != 0 || pb_state[2] !== 1'b1) begin
      errors++; $display("FAIL thresh1_glitch: presses %0d releases %0d state %b want 0/0/1", press_cnt[2], rel_cnt[2], pb_state[2]);
    end
  endtask

  task automatic test_simultaneous();
    int s;
    thresh = 16'd5;
    pb_in[3] = 1'b0;
    tick(12);
    clear_events();
    pb_in[0] = 1'b0;
    pb_in[3] = 1'b1;
    s = cyc;
    tick(12);
    checks++;
    if (press_cnt[0] != 1 || rel_cnt[3] != 1 || press_cyc[0] != s + 8 || rel_cyc[3] != s + 8) begin
      errors++; $display("FAIL simultaneous: press0 edge %0d release3 edge %0d want both 8", press_cyc[0] - s, rel_cyc[3] - s);
    end
    // Lower the threshold while the release of ch0 is 50 cycles into counting.
    thresh = 16'd100;
    clear_events();
    pb_in[0] = 1'b1;
    s = cyc;
    tick(52);
    checks++;
    if (rel_cnt[0] != 0) begin
      errors++; $display("FAIL thresh_lower_early: %0d releases before lowering, want 0", rel_cnt[0]);
    end
    thresh = 16'd5;
    tick(5);
    checks++;
    if (rel_cnt[0] != 1 || rel_cyc[0] != s + 53) begin
      errors++; $display("FAIL thresh_lower: count %0d at edge %0d want 1 at 53", rel_cnt[0], rel_cyc[0] - s);
    end
  endtask

  task automatic test_reset_midcount();
    int s;
    thresh = 16'd10;
    clear_events();
    pb_in[1] = 1'b0;
    tick(8);
    rst = 1'b1;
    pb_in[1] = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(15);
    checks++;
    if (press_cnt[1] != 0 || rel_cnt[1] != 0 || pb_state !== 4'b1111) begin
      errors++; $display("FAIL reset_midcount: presses %0d releases %0d state %b want 0/0/1111", press_cnt[1], rel_cnt[1], pb_state);
    end
    pb_in[1] = 1'b0;
    s = cyc;
    tick(16);
    checks++;
    if (press_cnt[1] != 1 || press_cyc[1] != s + 13) begin
      errors++; $display("FAIL reset_clears_cnt: count %0d at edge %0d want 1 at 13", press_cnt[1], press_cyc[1] - s);
    end
    pb_in[1] = 1'b1;
    tick(15);
  endtask

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  task automatic test_long_press();
    int s;
    int s2;
    thresh = 16'd2;
    clear_events();
    pb_in[0] = 1'b0;
    s = cyc;
    tick(55);
    checks++;
    if (press_cyc[0] != s + 5 || long_cnt[0] != 1 || long_cyc[0] != s + 25) begin
      errors++; $display("FAIL long_press: count %0d at edge %0d want 1 at 25", long_cnt[0], long_cyc[0] - s);
    end
    pb_in[0] = 1'b1;
    tick(10);
    clear_events();
    pb_in[0] = 1'b0;
    tick(15);
    pb_in[0] = 1'b1;
    tick(25);
    checks++;
    if (long_cnt[0] != 0 || press_cnt[0] != 1 || rel_cnt[0] != 1) begin
      errors++; $display("FAIL short_hold: long %0d press %0d release %0d want 0/1/1", long_cnt[0], press_cnt[0], rel_cnt[0]);
    end
    clear_events();
    pb_in[0] = 1'b0;
    tick(15);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    s2 = cyc;
    tick(35);
    checks++;
    if (press_cnt[0] != 2 || long_cnt[0] != 1 || long_cyc[0] != s2 + 25) begin
      errors++; $display("FAIL reset_mid_hold: long %0d at edge %0d want 1 at 25", long_cnt[0], long_cyc[0] - s2);
    end
    pb_in[0] = 1'b1;
    tick(10);
  endtask
`else
  task automatic test_long_press();
    checks++;
    if (long_total != 0) begin
      errors++; $display("FAIL long_press_tied: %0d pulses seen, want 0", long_total);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_threshold_edge();
    test_simultaneous();
    test_reset_midcount();
    test_long_press();
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL mutual_exclusion: %0d cycles with press and release together", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
